adder_inverse_seq: RTL

ADDER_INVERSE_SEQ -- requirements
Module: adder_inverse_seq

---
 rtl/adder_inverse_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/adder_inverse_seq.sv
// Sequential inverse adder: recovers the unknown addend (minuend - subtrahend) CHUNK bits per cycle.
// Optional zero-bubble DONE->CALC handoff enabled by defining ADDER_INVERSE_BACK2BACK_EN.

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// CALC  | subtracting one chunk per cycle, LSB chunk first
// DONE  | result and flags held until out_valid & out_ready
module adder_inverse_seq #(
  parameter int WIDTH = 140,
  parameter int CHUNK = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             underflow,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   min_q;
  logic [WIDTH-1:0] sub_q;
  logic             borrow_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] min_chunk;
  logic [CHUNK-1:0] sub_chunk;
  logic [CHUNK:0]   chunk_res;
  logic             chunk_borrow;
  logic             last_chunk;
  logic             accept;

  assign min_chunk    = min_q[idx_q*CHUNK +: CHUNK];
  assign sub_chunk    = sub_q[idx_q*CHUNK +: CHUNK];
  // One extra bit on the left catches the borrow out of this chunk.
  assign chunk_res    = {1'b0, min_chunk} - {1'b0, sub_chunk} - {{CHUNK{1'b0}}, borrow_q};
  assign chunk_borrow = chunk_res[CHUNK];
  assign last_chunk   = (idx_q == IDXW'(NCHUNK - 1));
  assign accept       = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = CALC;
      end
      CALC: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef ADDER_INVERSE_BACK2BACK_EN
        in_ready = out_ready;
`else
        in_ready = 1'b0;
`endif
        if (out_ready) state_nxt = accept ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      min_q     <= '0;
      sub_q     <= '0;
      borrow_q  <= 1'b0;
      idx_q     <= '0;
      diff      <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        min_q     <= minuend;
        sub_q     <= subtrahend;
        borrow_q  <= 1'b0;
        idx_q     <= '0;
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end else if (state == CALC) begin
        diff[idx_q*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
        borrow_q <= chunk_borrow;
        idx_q    <= last_chunk ? '0 : idx_q + 1'b1;
        if (last_chunk) begin
          // Top minuend bit against the final borrow decides fit / wrap.
          overflow  <= min_q[WIDTH] & ~chunk_borrow;
          underflow <= ~min_q[WIDTH] & chunk_borrow;
        end
      end
    end
  end

endmodule
